// File: rtl/sdram_read_frame_if.sv
// sdram_read_frame_if
// Groups the two data-path bundles of the frame reader:
//   - Avalon-MM burst read bus (address, burstcount, read, waitrequest, readdata, readdatavalid)
//   - valid/ready RGB pixel stream (r/g/b, pix_valid, pix_sof, pix_ready)
// master: the frame reader side (drives requests and pixels).
// slave:  the memory / consumer side (drives waitrequest, read data and pix_ready).
interface sdram_read_frame_if;
    logic [28:0] avm_address;
    logic [7:0]  avm_burstcount;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [63:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [7:0]  r_out;
    logic [7:0]  g_out;
    logic [7:0]  b_out;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;

    modport master (
        output avm_address, avm_burstcount, avm_read,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output r_out, g_out, b_out, pix_valid, pix_sof,
        input  pix_ready
    );

    modport slave (
        input  avm_address, avm_burstcount, avm_read,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  r_out, g_out, b_out, pix_valid, pix_sof,
        output pix_ready
    );
endinterface

// File: rtl/sdram_read_frame.sv
// sdram_read_frame
// Avalon-MM burst read master: fetches one packed RGB frame (two pixels per 64-bit word,
// {8'd0,b,g,r} per 32-bit half) from a base word address, buffers words in a FIFO and
// streams them out as a valid/ready pixel stream.
// Ports:
//   clk_100          system clock (rising edge)
//   reset_n          asynchronous active-low reset
//   start_read_frame one-cycle pulse starting a frame fetch (ignored unless idle)
//   reg_addr_buf     frame base word address, bits [28:0] sampled at start
//   bus              Avalon read bus + pixel stream (sdram_read_frame_if.master)
//   busy             frame in progress
//   frame_done       one-cycle pulse after the last pixel is accepted
//   underflow_cnt    starvation counter
// Optional feature: define SDRAM_READ_UNDERFLOW_CNT_EN to build the starvation counter;
// otherwise underflow_cnt is tied to 0.
module sdram_read_frame #(
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter int unsigned BURST_LEN    = 32,
    parameter int unsigned FIFO_DEPTH   = 256
) (
    input  logic                      clk_100,
    input  logic                      reset_n,
    input  logic                      start_read_frame,
    input  logic [31:0]               reg_addr_buf,
    sdram_read_frame_if.master        bus,
    output logic                      busy,
    output logic                      frame_done,
    output logic [15:0]               underflow_cnt
);
    localparam int unsigned NUM_BURSTS = FRAME_PIXELS / (2 * BURST_LEN);
    localparam int unsigned BCNT_W     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int unsigned PIX_W      = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] LAST_BURST = BCNT_W'(NUM_BURSTS - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX   = PIX_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {StIdle, StArb, StReq, StDrain} state_e;

    state_e            r_state, w_state_d;
    logic [28:0]       r_addr;
    logic [BCNT_W-1:0] r_burst_cnt;
    logic [PTR_W:0]    r_inflight;
    logic              r_busy, r_done;
    logic [63:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W:0]    r_wptr, r_rptr;
    logic [63:0]       r_word;
    logic              r_word_vld, r_sel;
    logic [23:0]       r_pix;
    logic              r_pix_valid;
    logic [PIX_W-1:0]  r_pix_cnt;

    logic              w_accept_start, w_req_fire, w_read, w_finish;
    logic              w_push, w_pop, w_out_load, w_word_free, w_xfer, w_last_xfer, w_credit_ok;
    logic [PTR_W:0]    w_fifo_used;
    logic              w_unused;

    // Stale read data arriving after an abort finds inflight==0 and is dropped.
    assign w_push      = bus.avm_readdatavalid && (r_inflight != '0);
    assign w_fifo_used = r_wptr - r_rptr;
    // Requested-but-unreturned words count as occupied, so the FIFO can never overflow.
    assign w_credit_ok = (32'(w_fifo_used) + 32'(r_inflight)) <= (FIFO_DEPTH - BURST_LEN);

    assign w_xfer      = r_pix_valid && bus.pix_ready;
    assign w_last_xfer = w_xfer && (r_pix_cnt == LAST_PIX);
    assign w_out_load  = r_word_vld && (!r_pix_valid || bus.pix_ready);
    // Refill the word holder in the same cycle its upper half leaves, keeping 1 pixel/cycle.
    assign w_word_free = !r_word_vld || (w_out_load && r_sel);
    assign w_pop       = w_word_free && (r_wptr != r_rptr);

    always_comb begin
        w_state_d      = r_state;
        w_accept_start = 1'b0;
        w_req_fire     = 1'b0;
        w_read         = 1'b0;
        w_finish       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start_read_frame) begin
                    w_accept_start = 1'b1;
                    w_state_d      = StArb;
                end
            end
            StArb: begin
                if (w_credit_ok) w_state_d = StReq;
            end
            StReq: begin
                w_read = 1'b1;
                if (!bus.avm_waitrequest) begin
                    w_req_fire = 1'b1;
                    w_state_d  = (r_burst_cnt == LAST_BURST) ? StDrain : StArb;
                end
            end
            StDrain: begin
                if (w_last_xfer) begin
                    w_finish  = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_burst_cnt <= '0;
            r_inflight  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_word      <= '0;
            r_word_vld  <= 1'b0;
            r_sel       <= 1'b0;
            r_pix       <= '0;
            r_pix_valid <= 1'b0;
            r_pix_cnt   <= '0;
        end else begin
            r_done <= w_finish;
            if (w_accept_start) begin
                r_addr      <= reg_addr_buf[28:0];
                r_burst_cnt <= '0;
                r_pix_cnt   <= '0;
                r_busy      <= 1'b1;
            end else begin
                if (w_req_fire) begin
                    r_addr      <= r_addr + 29'(BURST_LEN);
                    r_burst_cnt <= r_burst_cnt + BCNT_W'(1);
                end
                if (w_xfer)   r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                if (w_finish) r_busy    <= 1'b0;
            end

            unique case ({w_req_fire, w_push})
                2'b10:   r_inflight <= r_inflight + (PTR_W+1)'(BURST_LEN);
                2'b11:   r_inflight <= r_inflight + (PTR_W+1)'(BURST_LEN) - (PTR_W+1)'(1);
                2'b01:   r_inflight <= r_inflight - (PTR_W+1)'(1);
                default: r_inflight <= r_inflight;
            endcase

            if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);

            if (w_pop) begin
                r_word     <= r_mem[r_rptr[PTR_W-1:0]];
                r_word_vld <= 1'b1;
                r_sel      <= 1'b0;
                r_rptr     <= r_rptr + (PTR_W+1)'(1);
            end else if (w_out_load) begin
                if (r_sel) r_word_vld <= 1'b0;
                else       r_sel      <= 1'b1;
            end

            if (w_out_load) begin
                r_pix       <= r_sel ? r_word[55:32] : r_word[23:0];
                r_pix_valid <= 1'b1;
            end else if (bus.pix_ready) begin
                r_pix_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_100) begin
        if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= bus.avm_readdata;
    end

`ifdef SDRAM_READ_UNDERFLOW_CNT_EN
    logic        r_first_done;
    logic [15:0] r_uf_cnt;

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_first_done <= 1'b0;
            r_uf_cnt     <= '0;
        end else if (w_accept_start) begin
            r_first_done <= 1'b0;
            r_uf_cnt     <= '0;
        end else begin
            if (w_xfer) r_first_done <= 1'b1;
            if (r_busy && bus.pix_ready && !r_pix_valid && r_first_done &&
                (r_uf_cnt != 16'hFFFF)) begin
                r_uf_cnt <= r_uf_cnt + 16'd1;
            end
        end
    end

    assign underflow_cnt = r_uf_cnt;
`else
    assign underflow_cnt = 16'd0;
`endif

    assign bus.avm_read       = w_read;
    assign bus.avm_address    = r_addr;
    assign bus.avm_burstcount = w_read ? 8'(BURST_LEN) : 8'd0;
    assign bus.r_out          = r_pix[7:0];
    assign bus.g_out          = r_pix[15:8];
    assign bus.b_out          = r_pix[23:16];
    assign bus.pix_valid      = r_pix_valid;
    assign bus.pix_sof        = r_pix_valid && r_busy && (r_pix_cnt == '0);
    assign busy               = r_busy;
    assign frame_done         = r_done;

    assign w_unused = ^{reg_addr_buf[31:29], r_word[63:56], r_word[31:24]};
endmodule

// File: tb/tb_sdram_read_frame.sv
module tb_sdram_read_frame;
    localparam int unsigned FP = 256;
    localparam int unsigned BL = 32;
    localparam int unsigned FD = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_in = '0;
    logic        busy, frame_done;
    logic [15:0] uf;

    sdram_read_frame_if bus();

    sdram_read_frame #(
        .FRAME_PIXELS (FP),
        .BURST_LEN    (BL),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk_100          (clk),
        .reset_n          (rst_n),
        .start_read_frame (start),
        .reg_addr_buf     (base_in),
        .bus              (bus),
        .busy             (busy),
        .frame_done       (frame_done),
        .underflow_cnt    (uf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- Avalon slave model ----------------
    logic [28:0] cur_base = '0;
    int unsigned wr_left = 0;
    int unsigned lat = 2;
    logic [28:0] acc_q[$];
    logic [28:0] acc_log[$];
    int unsigned ret_left = 0;
    int unsigned ret_wait = 0;
    logic [28:0] ret_addr = '0;

    assign bus.avm_waitrequest = (wr_left != 0);

    initial begin
        bus.avm_readdata      = '0;
        bus.avm_readdatavalid = 1'b0;
    end

    always @(posedge clk) begin
        logic [28:0] k;
        bus.avm_readdatavalid <= 1'b0;
        if (bus.avm_read === 1'b1) begin
            if (wr_left != 0) begin
                wr_left <= wr_left - 1;
            end else begin
                acc_q.push_back(bus.avm_address);
                acc_log.push_back(bus.avm_address);
            end
        end
        if (ret_left == 0 && acc_q.size() != 0) begin
            ret_addr = acc_q.pop_front();
            ret_left = BL;
            ret_wait = lat;
        end else if (ret_left != 0) begin
            if (ret_wait != 0) begin
                ret_wait--;
            end else begin
                k = ret_addr - cur_base;
                bus.avm_readdata      <= {8'd0, 24'(2 * k + 1), 8'd0, 24'(2 * k)};
                bus.avm_readdatavalid <= 1'b1;
                ret_addr = ret_addr + 29'd1;
                ret_left--;
            end
        end
    end

    // ---------------- pixel consumer ----------------
    int unsigned cyc = 0;
    int          ready_mode = 0;

    initial bus.pix_ready = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #1;
        case (ready_mode)
            0:       bus.pix_ready = 1'b1;
            1:       bus.pix_ready = cyc[0];
            2:       bus.pix_ready = ($urandom_range(0, 3) != 0);
            default: bus.pix_ready = 1'b0;
        endcase
    end

    // ---------------- monitor ----------------
    int unsigned exp_n = 0;
    int unsigned done_cnt = 0;
    int unsigned exp_uf = 0;
    int unsigned last_xfer_cyc = 0;
    bit          sof_seen = 0;
    bit          prev_stall = 0;
    logic [23:0] prev_pix = '0;

    always @(negedge clk) begin
        logic [23:0] pix;
        pix = {bus.b_out, bus.g_out, bus.r_out};
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.pix_valid), 64'd1);
                check("hold_data", 64'(pix), 64'(prev_pix));
            end
            if (busy && bus.pix_ready && !bus.pix_valid && sof_seen) exp_uf++;
            if (bus.pix_valid && bus.pix_ready) begin
                check("pix_data", 64'(pix), 64'(exp_n));
                check("pix_sof", 64'(bus.pix_sof), 64'(exp_n == 0));
                exp_n++;
                sof_seen = 1;
                last_xfer_cyc = cyc;
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_pix   = pix;
            if (frame_done) begin
                done_cnt++;
                check("done_timing", 64'(cyc), 64'(last_xfer_cyc + 1));
                check("busy_fall", 64'(busy), 64'd0);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic start_frame(input logic [31:0] b);
        @(posedge clk); #1;
        cur_base = b[28:0];
        acc_log.delete();
        exp_n = 0; sof_seen = 0; exp_uf = 0; done_cnt = 0;
        base_in = b;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (frame_done !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("frame_done_seen", 64'(frame_done), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_bursts(input int unsigned n);
        int t;
        t = 0;
        while (acc_log.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("burst_wait", 64'(acc_log.size() >= n), 64'd1);
    endtask

    task automatic frame_checks(input logic [28:0] a0, input logic [28:0] a3);
        check("pix_count", 64'(exp_n), 64'(FP));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("burst_count", 64'(acc_log.size()), 64'd4);
        check("addr_first", 64'(acc_log[0]), 64'(a0));
        check("addr_last", 64'(acc_log[3]), 64'(a3));
        check("busy_idle", 64'(busy), 64'd0);
`ifdef SDRAM_READ_UNDERFLOW_CNT_EN
        check("underflow_cnt", 64'(uf), 64'(exp_uf));
`else
        check("underflow_cnt", 64'(uf), 64'd0);
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_read"}, 64'(bus.avm_read), 64'd0);
        check({tag, "_addr"}, 64'(bus.avm_address), 64'd0);
        check({tag, "_bcnt"}, 64'(bus.avm_burstcount), 64'd0);
        check({tag, "_pvalid"}, 64'(bus.pix_valid), 64'd0);
        check({tag, "_sof"}, 64'(bus.pix_sof), 64'd0);
        check({tag, "_rgb"}, 64'({bus.b_out, bus.g_out, bus.r_out}), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(frame_done), 64'd0);
        check({tag, "_uf"}, 64'(uf), 64'd0);
    endtask

    typedef struct {
        logic [31:0] base;
        int          ready_mode;
        int unsigned wr_hold;
        int unsigned lat;
        logic [28:0] exp_a0;
        logic [28:0] exp_a3;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_1000, 0, 0, 2, 29'h0000_1000, 29'h0000_1060};
        vecs[1] = '{32'h1FFF_FFF0, 1, 3, 4, 29'h1FFF_FFF0, 29'h0000_0050};
        vecs[2] = '{32'hE000_1000, 2, 0, 1, 29'h0000_1000, 29'h0000_1060};
        vecs[3] = '{32'h0000_8000, 0, 0, 10, 29'h0000_8000, 29'h0000_8060};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Table-driven full frames.
        for (int i = 0; i < 4; i++) begin
            ready_mode = vecs[i].ready_mode;
            lat        = vecs[i].lat;
            wr_left    = vecs[i].wr_hold;
            start_frame(vecs[i].base);
            wait_done();
            frame_checks(vecs[i].exp_a0, vecs[i].exp_a3);
        end

        // Waitrequest stall on the first request; also request latency.
        ready_mode = 0; lat = 2; wr_left = 5;
        start_frame(32'h0000_1000);
        @(negedge clk);
        check("lat_arb_read", 64'(bus.avm_read), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("wr_read", 64'(bus.avm_read), 64'd1);
            check("wr_addr", 64'(bus.avm_address), 64'h1000);
            check("wr_bcnt", 64'(bus.avm_burstcount), 64'd32);
        end
        @(negedge clk);
        check("wr_one_burst", 64'(acc_log.size()), 64'd1);
        check("wr_read_drop", 64'(bus.avm_read), 64'd0);
        wait_done();
        frame_checks(29'h1000, 29'h1060);

        // Back-pressure: credit stops requests after two bursts.
        ready_mode = 3; lat = 2;
        start_frame(32'h0000_2000);
        repeat (400) @(negedge clk);
        check("bp_bursts", 64'(acc_log.size()), 64'd2);
        check("bp_no_read", 64'(bus.avm_read), 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        ready_mode = 0;
        wait_done();
        frame_checks(29'h2000, 29'h2060);

        // Start pulse mid-frame is ignored.
        start_frame(32'h0000_3000);
        wait_bursts(1);
        @(posedge clk); #1;
        base_in = 32'h0000_5000;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        wait_done();
        frame_checks(29'h3000, 29'h3060);
        check("mid_addr1", 64'(acc_log[1]), 64'h3020);

        // Reset mid-frame, then a clean refetch.
        lat = 6;
        start_frame(32'h0000_4000);
        wait_bursts(1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        wr_left = 0;
        #1;
        check_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 300 && (ret_left != 0 || acc_q.size() != 0); t++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("stale_pvalid", 64'(bus.pix_valid), 64'd0);
        check("stale_busy", 64'(busy), 64'd0);
        start_frame(32'h0000_4000);
        wait_done();
        frame_checks(29'h4000, 29'h4060);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
